// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;
  localparam int unsigned ADDR_W_DEF = 7;
  localparam int unsigned DATA_W_DEF = 32;
  localparam logic [4:0]  HALT_OPC   = 5'b01011;
  localparam int unsigned OPC_HI     = 31;
  localparam int unsigned OPC_LO     = 27;

  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry valid/ready buffer: output register plus one skid entry, with flush.
module fetch_skid_buffer #(
  parameter int unsigned W = 39
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);
  logic         skid_v;
  logic [W-1:0] skid_d;
  logic         pop;

  assign pop = out_valid && out_ready;
  assign occ = {1'b0, out_valid} + {1'b0, skid_v};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_v    <= 1'b0;
      skid_d    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_v    <= 1'b0;
    end else if (pop || !out_valid) begin
      // Skid entry is older than any incoming word, so it refills the output first.
      if (skid_v) begin
        out_data  <= skid_d;
        out_valid <= 1'b1;
        skid_v    <= in_valid;
        if (in_valid) skid_d <= in_data;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(in_valid && !flush && out_valid && skid_v && !out_ready));
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC ownership, credit-based read issue, branch squash and HALT detection.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = fetch_pkg::ADDR_W_DEF,
  parameter int unsigned       DATA_W   = fetch_pkg::DATA_W_DEF,
  parameter int unsigned       DEPTH    = 101,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0]        HALT_OPC = fetch_pkg::HALT_OPC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              done
);
  import fetch_pkg::*;

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(DEPTH - 1);

  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, req_pc_q, target_clamped;
  logic              inflight_q, squash_q;
  logic              resp_v, halt_det, push, pop, flush, issue;
  logic [1:0]        occ;
  logic [2:0]        credit_used, credit_lim;
  logic [ADDR_W+DATA_W-1:0] buf_out;

  assign imem_addr      = pc_q;
  assign pop            = instr_valid && instr_ready;
  assign flush          = (state_q == RUN) && branch_taken;
  assign target_clamped = ({1'b0, branch_target} >= DEPTH_EXT) ? '0 : branch_target;

  // A redirect in the response cycle drops the returning word, HALT opcode included.
  assign resp_v   = (state_q == RUN) && inflight_q && !squash_q && !branch_taken;
  assign halt_det = resp_v && (imem_rdata[OPC_HI:OPC_LO] == HALT_OPC);
  assign push     = resp_v && !halt_det;

  assign credit_used = {1'b0, occ} + {2'b00, inflight_q};
  assign credit_lim  = 3'd2 + {2'b00, pop};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (halt_det) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    done  = 1'b0;
    case (state_q)
      RUN:     issue = !branch_taken && (credit_used < credit_lim);
      HALT:    done  = (occ == 2'd0);
      default: ;
    endcase
  end

  assign imem_rd = issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      inflight_q <= issue;
      squash_q   <= issue && halt_det;
      if (issue) req_pc_q <= pc_q;
      if (branch_taken && state_q != HALT) pc_q <= target_clamped;
      else if (issue) pc_q <= (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
    end
  end

  fetch_skid_buffer #(.W(ADDR_W + DATA_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (push),
    .in_data   ({req_pc_q, imem_rdata}),
    .out_ready (instr_ready),
    .out_valid (instr_valid),
    .out_data  (buf_out),
    .occ       (occ)
  );

  assign instr    = buf_out[DATA_W-1:0];
  assign instr_pc = buf_out[ADDR_W+DATA_W-1:DATA_W];
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized bench for fetch_sequencer against a stream-level program model.
module tb_fetch_sequencer;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int DEPTH = 101;
  localparam logic [4:0] HOPC = 5'b01011;

  logic clk = 1'b0;
  logic rst, start, branch_taken, imem_rd, instr_valid, instr_ready, done;
  logic [AW-1:0] branch_target, imem_addr, instr_pc;
  logic [DW-1:0] imem_rdata = '0;
  logic [DW-1:0] instr;
  logic [DW-1:0] mem [0:127];

  int unsigned n_checks = 0, n_fail = 0;
  logic mon_en = 1'b0, halt_mode = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(7'd0), .HALT_OPC(HOPC)) dut (
    .clk(clk), .rst(rst), .start(start), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready), .done(done)
  );

  always @(posedge clk) if (imem_rd) imem_rdata <= mem[imem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [AW-1:0] clampf(input logic [AW-1:0] t);
    return (int'(t) >= DEPTH) ? '0 : t;
  endfunction

  function automatic logic is_halt(input logic [DW-1:0] w);
    return w[31:27] == HOPC;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = $urandom;
    if (is_halt(w)) w[27] = ~w[27];
    return w;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 128; i++) mem[i] = rand_word();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; branch_taken = 1'b0; branch_target = '0; instr_ready = 1'b0;
    tick(); tick();
    check_eq("rst_valid", 32'(instr_valid), 0);
    check_eq("rst_rd", 32'(imem_rd), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_pc", 32'(imem_addr), 0);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_instr_pc", 32'(instr_pc), 0);
    rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int exp_pc);
    check_eq({tag, "_valid"}, 32'(instr_valid), 1);
    check_eq({tag, "_pc"}, 32'(instr_pc), 32'(exp_pc));
    check_eq({tag, "_instr"}, instr, mem[exp_pc]);
  endtask

  // Program-level model: the accepted stream must walk the PC sequence from the start
  // address, restart at each clamped redirect, and never deliver a HALT word.
  logic [AW-1:0] exp_pc, idle_pc, prev_pc;
  logic [DW-1:0] prev_instr;
  logic running, prev_hold;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      idle_pc = '0; running = 1'b0; prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check_eq("hold_valid", 32'(instr_valid), 1);
        check_eq("hold_instr", instr, prev_instr);
        check_eq("hold_pc", 32'(instr_pc), 32'(prev_pc));
      end
      if (!halt_mode) check_eq("done_low", 32'(done), 0);
      if (running && instr_valid && instr_ready) begin
        if (is_halt(mem[exp_pc])) check_eq("post_halt_valid", 32'(instr_valid), 0);
        else begin
          check_eq("model_pc", 32'(instr_pc), 32'(exp_pc));
          check_eq("model_instr", instr, mem[exp_pc]);
          exp_pc = nxt(exp_pc);
        end
      end
      if (branch_taken) begin
        if (running) exp_pc = clampf(branch_target);
        else idle_pc = clampf(branch_target);
      end
      if (start && !running) begin
        running = 1'b1;
        exp_pc = idle_pc;
      end
      prev_hold  = instr_valid && !instr_ready && !branch_taken;
      prev_instr = instr;
      prev_pc    = instr_pc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Sequential run ending on HALT at word 5.
    fill_mem(); mem[5] = {HOPC, 27'h0123456};
    do_reset();
    instr_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    check_eq("seq_c1_rd", 32'(imem_rd), 1);
    check_eq("seq_c1_addr", 32'(imem_addr), 0);
    tick();
    check_eq("seq_c2_valid", 32'(instr_valid), 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk_out("seq", k);
      check_eq("seq_done_low", 32'(done), 0);
      tick();
    end
    check_eq("seq_halt_valid", 32'(instr_valid), 0);
    check_eq("seq_done", 32'(done), 1);
    check_eq("seq_halt_rd", 32'(imem_rd), 0);
    start = 1'b1; branch_taken = 1'b1; branch_target = 7'd3;
    tick(); start = 1'b0; branch_taken = 1'b0;
    tick(); tick();
    check_eq("seq_done_sticky", 32'(done), 1);
    check_eq("seq_quiet", 32'(instr_valid), 0);
    check_eq("seq_quiet_rd", 32'(imem_rd), 0);

    // Backpressure for five cycles mid-stream.
    fill_mem();
    do_reset();
    instr_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    instr_ready = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk_out("bp_hold", 2);
      check_eq("bp_rd", 32'(imem_rd), 0);
      tick();
    end
    instr_ready = 1'b1; #1;
    check_eq("bp_resume_rd", 32'(imem_rd), 1);
    check_eq("bp_resume_addr", 32'(imem_addr), 4);
    for (int k = 0; k < 5; k++) begin
      chk_out("bp_drain", 2 + k);
      tick();
    end

    // Branch to 40 while pc 7 is in flight.
    do_reset();
    instr_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    chk_out("br_pre", 6);
    branch_taken = 1'b1; branch_target = 7'd40; #1;
    check_eq("br_rd_off", 32'(imem_rd), 0);
    tick(); branch_taken = 1'b0; #1;
    check_eq("br_t1_valid", 32'(instr_valid), 0);
    check_eq("br_t1_rd", 32'(imem_rd), 1);
    check_eq("br_t1_addr", 32'(imem_addr), 40);
    tick();
    check_eq("br_t2_valid", 32'(instr_valid), 0);
    tick();
    chk_out("br_t3", 40);
    tick();
    chk_out("br_t4", 41);

    // Branch beats HALT detection of word 9.
    mem[9] = {HOPC, 27'h7654321};
    do_reset();
    instr_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    chk_out("bh_pre", 8);
    branch_taken = 1'b1; branch_target = 7'd20; tick(); branch_taken = 1'b0;
    check_eq("bh_t1_valid", 32'(instr_valid), 0);
    check_eq("bh_t1_done", 32'(done), 0);
    tick(); tick();
    chk_out("bh_t3", 20);
    check_eq("bh_done", 32'(done), 0);
    tick(); tick();
    chk_out("bh_t5", 22);
    check_eq("bh_done2", 32'(done), 0);
    mem[9] = rand_word();

    // Wrap from DEPTH-1 and clamp of an out-of-range target.
    do_reset();
    instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 7'd98; tick(); branch_taken = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      chk_out("wrap", (98 + k) % DEPTH);
      if (k < 4) tick();
    end
    branch_taken = 1'b1; branch_target = 7'd120; tick(); branch_taken = 1'b0;
    tick(); tick();
    chk_out("clamp", 0);

    // Reset in the middle of a run.
    do_reset();
    instr_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    check_eq("mr_pre_valid", 32'(instr_valid), 1);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    check_eq("mr_valid", 32'(instr_valid), 0);
    check_eq("mr_rd", 32'(imem_rd), 0);
    check_eq("mr_done", 32'(done), 0);
    check_eq("mr_pc", 32'(imem_addr), 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk_out("mr_restart", 0);

    // Randomized ready and redirects, no HALT words in memory.
    for (int seg = 0; seg < 6; seg++) begin
      fill_mem();
      halt_mode = 1'b0; mon_en = 1'b1;
      do_reset();
      if (seg % 2 == 1) begin
        branch_taken = 1'b1; branch_target = 7'($urandom_range(0, 127)); tick(); branch_taken = 1'b0;
      end
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 300; c++) begin
        instr_ready   = ($urandom_range(0, 9) < 7);
        branch_taken  = ($urandom_range(0, 24) == 0);
        branch_target = 7'($urandom_range(0, 127));
        tick();
      end
      branch_taken = 1'b0;
      tick();
      mon_en = 1'b0;
    end

    // Randomized runs ending on a HALT word at a random address.
    for (int seg = 0; seg < 3; seg++) begin
      int h;
      fill_mem();
      h = $urandom_range(0, DEPTH - 1);
      mem[h] = {HOPC, 27'($urandom)};
      halt_mode = 1'b1; mon_en = 1'b1;
      do_reset();
      branch_taken = 1'b1; branch_target = 7'($urandom_range(0, DEPTH - 1)); tick(); branch_taken = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 800 && !done; c++) begin
        instr_ready = ($urandom_range(0, 9) < 6);
        tick();
      end
      check_eq("halt_done", 32'(done), 1);
      check_eq("halt_drained_to", 32'(exp_pc), 32'(h));
      instr_ready = 1'b1;
      repeat (4) tick();
      check_eq("halt_quiet", 32'(instr_valid), 0);
      check_eq("halt_done_sticky", 32'(done), 1);
      mon_en = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the synchronous instruction memory for the single-issue processor.
- Owns the program counter and issues one read per cycle when buffer credit allows.
- Presents fetched words to decode over a valid/ready handshake.
- Applies branch redirects with squash, and detects the HALT opcode to stop fetching and assert done.

Parameters:
- ADDR_W, 7, PC and memory address width.
- DATA_W, 32, instruction width.
- DEPTH, 101, number of valid instruction words; PC wraps from DEPTH-1 to 0.
- RESET_PC, 0, PC value after reset.
- HALT_OPC, 5'b01011, opcode in bits [31:27] that terminates the program.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; leaves IDLE and begins fetching at the current PC.
- branch_taken  in  1  redirect request from execute, one-cycle pulse.
- branch_target  in  ADDR_W  redirect address, sampled when branch_taken=1.
- imem_addr  out  ADDR_W  read address to instruction memory (equals PC register).
- imem_rd  out  1  read strobe; memory returns imem_rdata exactly one cycle later.
- imem_rdata  in  DATA_W  read data from memory.
- instr  out  DATA_W  instruction presented to decode.
- instr_pc  out  ADDR_W  address of the word on instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts; transfer occurs when instr_valid && instr_ready.
- done  out  1  program finished; sticky until rst.

Behaviour:
Interface rule:
- One clock, clk.
- Reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.

Reset values:
- pc=RESET_PC, state=IDLE, imem_rd=0, instr_valid=0, instr=0, instr_pc=0, done=0.
- Output register, skid entry and in-flight flag all cleared.

States:
- IDLE:
  - No reads issued.
  - start → RUN.
  - branch_taken in IDLE loads pc=branch_target and stays in IDLE.
- RUN:
  - Issue rule: imem_rd=1 when occ + inflight − (instr_valid && instr_ready) < 2, where occ = number of filled entries (output register + 1-entry skid, 0..2).
  - On issue: record req_pc=pc, set inflight, then pc <= (pc==DEPTH-1) ? 0 : pc+1.
- HALT:
  - Entered when a non-squashed response has imem_rdata[31:27]==HALT_OPC.
  - The HALT word itself is never presented to decode.
  - No further reads are issued.
  - A read issued in the same cycle as HALT detection is marked squashed and its response is dropped.
  - Buffered instructions continue to drain.
  - done=1 on the first cycle with state==HALT and occ==0, and stays 1.
  - Only rst leaves HALT; start and branch_taken are ignored there.

Response handling (cycle after issue):
- The word is written to the output register if it is empty or being consumed this cycle; otherwise it is written to the skid entry.
- The skid entry moves to the output register when the output register is consumed.
- Ordering is strictly FIFO.
- The credit rule guarantees no response is ever lost; an overflow is an assertion failure.

Branch redirect (RUN):
- On branch_taken, in the same cycle:
  - pc <= branch_target.
  - Output register and skid cleared (instr_valid=0 next cycle).
  - Any in-flight response is marked squashed and discarded.
  - imem_rd=0 in the redirect cycle.
- The first read of branch_target is issued the following cycle.
- Precedence: branch_taken beats HALT detection of an in-flight word (that word is squashed), and beats a simultaneous instr_ready transfer only for buffer contents. The word on instr in that cycle is still considered accepted if instr_ready=1.

Latency:
- start at cycle 0 → first imem_rd at cycle 1 → instr_valid at cycle 3.
- branch_taken at t → instr_valid with instr_pc=target at t+3.
- Steady state with instr_ready=1 sustains one instruction per cycle.

Boundary cases:
- branch_target ≥ DEPTH is clamped to 0.
- rst during RUN or HALT takes effect next edge; in-flight data is ignored.
- Holding instr_ready=0 leaves instr/instr_pc stable while instr_valid=1.

Decomposition:
- Package fetch_pkg: state enum {IDLE, RUN, HALT}; HALT_OPC constant; opcode field bounds 31:27; ADDR_W/DATA_W defaults.
- Sub-module fetch_skid_buffer: 2-entry (output register + skid) valid/ready buffer with flush input and occupancy output.
- The PC/issue/squash FSM remains in fetch_sequencer.

Test Plan:
- Sequential run: memory words 0..4 = non-halt, word 5 = HALT_OPC; start, instr_ready=1 → instr_pc 0,1,2,3,4 on consecutive cycles from cycle 3, word 5 never valid, done=1 one cycle after pc 4 is accepted.
- Backpressure: instr_ready=0 for 5 cycles mid-stream → imem_rd stops after two outstanding, instr stable, then resume with no gap, no duplicate and no loss (instr_pc strictly consecutive).
- Branch: branch_taken with target 40 while pc=7 in flight → 7 never presented, next instr_pc=40 exactly 3 cycles after the pulse.
- Branch vs HALT: word 9 = HALT, branch_taken to 20 in the cycle word 9 returns → no halt, done=0, instr_pc=20 follows.
- Wrap and clamp: DEPTH=101, sequence runs pc 100 → next instr_pc=0; branch_target=120 → instr_pc=0.
- Reset mid-run: rst asserted during RUN with instr_valid=1 → next cycle instr_valid=0, imem_rd=0, done=0, pc=RESET_PC, state IDLE; start restarts from 0.
